dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
//==============================================================================
// dmem_responder: 256 x 16 data memory behind a four-phase req/ack handshake.
// Revision: 1.0
//==============================================================================
`default_nettype none

module dmem_responder #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        read_write,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [7:0]  access_count
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [7:0]  count_q, count_d;
    logic        mem_we;

    logic [15:0] mem_q [256];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        count_d = count_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req && !ack_q && !busy_q) begin
                    addr_d  = addr;
                    rw_d    = read_write;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Counter expiry is the commit edge; a reset on this edge
                // must also block the storage write.
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    count_d = count_q + 8'd1;
                    if (rw_q) begin
                        mem_we = !reset;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            rw_q    <= 1'b0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign rdata        = rdata_q;
    assign ack          = ack_q;
    assign busy         = busy_q;
    assign access_count = count_q;

endmodule

`default_nettype wire
